wb_scoreboard_arbiter: RTL and testbench
========================================

Name: wb_scoreboard_arbiter

Overview:
- Issue/writeback controller for the decode stage and its 32-entry register file.
- Scoreboards destination registers of in-flight instructions and stalls issue on RAW/WAW hazards or when the outstanding limit is reached.
- Arbitrates the register file's single write port (Result/RdWb/Wrenable) between the ALU and memory writeback sources.
- Sits between fetch and decode; the register-outputs drive the decode stage's write port.

Parameters:
- NREGS, 32, architectural register count (scoreboard depth).
- IDXW, 9, width of instruction register fields and of the write address.
- MAX_OUT, 8, maximum simultaneously pending destination registers (1..NREGS).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  fetch presents an instruction
- issue_instr  in  32  instruction: [31:27] opcode, [26:18] rd, [17:9] rs, [8:0] rt
- issue_ready  out  1  decode may accept (combinational, no hazard)
- alu_wb_valid  in  1  ALU result pending write
- alu_wb_rd  in  IDXW  ALU destination
- alu_wb_data  in  32  ALU result
- alu_wb_ready  out  1  ALU write granted this cycle
- mem_wb_valid / mem_wb_rd / mem_wb_data / mem_wb_ready: same as ALU, memory source
- rf_wr_en  out  1  to Wrenable
- rf_wr_addr  out  IDXW  to RdWb
- rf_wr_data  out  32  to Result
- pend_count  out  6  number of pending registers
- wb_err  out  1  sticky: write to a non-pending register

Behaviour:
- Reset: pending[] all 0, pend_count 0, rf_wr_en 0, rf_wr_addr 0, rf_wr_data 0, wb_err 0, rr_last = MEM (ALU wins the first tie). Reset mid-operation discards in-flight grants; no write is emitted in the cycle after reset.
- Register index: low 5 bits of each 9-bit field; upper bits ignored.
- Source decode by opcode:
  - 2,3,4,5 read rs and rt.
  - 8 reads rs.
  - 9 reads rd and rt.
  - 1,6,7,10 read none.
  - Opcodes 0 and 11..31 read none and write none (treated as NOP).
- Writes rd: opcodes 1,2,3,4,5,6,9.
- issue_ready = !(any read source pending | (writes_rd & pending[rd]) | (writes_rd & pend_count==MAX_OUT)).
  - issue_ready is asserted independent of issue_valid.
  - Non-writing instructions never stall on the limit.
- Issue fire = issue_valid & issue_ready. On fire with writes_rd: pending[rd] set at the clock edge.
- Arbitration, per cycle:
  - If exactly one of alu_wb_valid/mem_wb_valid is high, that source is granted.
  - If both are high, the source not equal to rr_last is granted; rr_last updates to the granted source.
  - Grant is signalled combinationally via the matching *_ready; a source holds valid/rd/data until ready.
- Write port:
  - Granted rd/data register into rf_wr_addr/rf_wr_data with rf_wr_en=1 one cycle after grant (latency 1).
  - rf_wr_en=0 when there is no grant; addr/data hold their last value.
- Scoreboard clear:
  - pending[rd] clears at the end of the cycle in which rf_wr_en is high for that address.
  - A dependent instruction sees issue_ready the cycle after rf_wr_en. Minimum writeback-to-dependent-issue = 2 cycles from grant.
- Simultaneous issue set and clear of the same register cannot both take effect: issue to a pending rd stalls. A set and a clear of different registers in one cycle both apply.
- pend_count = popcount(pending), registered, updated with pending. Never exceeds MAX_OUT.
- Grant to a non-pending register: the write is still performed; wb_err is set and held until reset.
- No combinational path from *_wb_valid to issue_ready.

Test Plan:
- Reset hold 2 cycles, then idle -> all outputs 0, issue_ready=1 for instr opcode 2 (ADD r1,r2,r3).
- Issue 0x10040403 (op2 rd1 rs2 rt3) -> pending[1]=1, pend_count=1.
  - Next cycle, op2 rd4 rs1 rt5: issue_ready=0.
  - ALU wb rd1 data 0xDEADBEEF: alu_wb_ready=1; next cycle rf_wr_en=1, addr=1, data=0xDEADBEEF.
  - The cycle after that: issue_ready=1, pend_count=0.
- Both sources valid for 3 cycles (ALU rd5, MEM rd6, each pending, holding while not ready) -> grants ALU, then MEM; rf_wr_en sequence addr 5 then 6, one per cycle.
- Issue 8 writes to r1..r8 -> pend_count=8.
  - 9th write (op6 rd9): issue_ready=0.
  - op7 branch: issue_ready=1.
  - One writeback: ready for op6 two cycles after grant.
- WAW: pending[3], issue op1 rd3 -> stall until r3 written; op9 reading r3 via rd also stalls.
- MEM wb to r12 (not pending) -> write performed, wb_err=1 sticky; assert reset mid-wb -> rf_wr_en=0 next cycle, wb_err=0, pend_count=0.

Source files
------------

// File: rtl/wb_scoreboard_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_scoreboard_arbiter
//  Purpose  : Register-file scoreboard with RAW/WAW issue stall, plus a
//             round-robin arbiter for the single register-file write port.
//  Revision : 1.0  initial release
// ============================================================================
module wb_scoreboard_arbiter #(
    parameter int NREGS   = 32,
    parameter int IDXW    = 9,
    parameter int MAX_OUT = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [31:0]     issue_instr,
    output logic            issue_ready,
    input  logic            alu_wb_valid,
    input  logic [IDXW-1:0] alu_wb_rd,
    input  logic [31:0]     alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            mem_wb_valid,
    input  logic [IDXW-1:0] mem_wb_rd,
    input  logic [31:0]     mem_wb_data,
    output logic            mem_wb_ready,
    output logic            rf_wr_en,
    output logic [IDXW-1:0] rf_wr_addr,
    output logic [31:0]     rf_wr_data,
    output logic [5:0]      pend_count,
    output logic            wb_err
);

    localparam int   RIW     = $clog2(NREGS);
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    logic [NREGS-1:0] pending_q,    pending_d;
    logic [5:0]       pend_count_q, pend_count_d;
    logic             rf_wr_en_q,   rf_wr_en_d;
    logic [IDXW-1:0]  rf_wr_addr_q, rf_wr_addr_d;
    logic [31:0]      rf_wr_data_q, rf_wr_data_d;
    logic             wb_err_q,     wb_err_d;
    logic             rr_last_q,    rr_last_d;

    logic [4:0]       opcode;
    logic [RIW-1:0]   rd_idx, rs_idx, rt_idx, grant_idx;
    logic             reads_rs, reads_rt, reads_rd, writes_rd;
    logic             grant_alu, grant_mem, issue_fire;
    logic [NREGS-1:0] set_mask, clr_mask;
    logic             unused_instr_bits;

    assign opcode = issue_instr[31:27];
    assign rd_idx = issue_instr[18 +: RIW];
    assign rs_idx = issue_instr[9  +: RIW];
    assign rt_idx = issue_instr[0  +: RIW];
    assign unused_instr_bits = ^{issue_instr[26:18+RIW], issue_instr[17:9+RIW],
                                 issue_instr[8:RIW]};

    always_comb begin
        reads_rs  = 1'b0;
        reads_rt  = 1'b0;
        reads_rd  = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            5'd2, 5'd3, 5'd4, 5'd5: begin
                reads_rs  = 1'b1;
                reads_rt  = 1'b1;
                writes_rd = 1'b1;
            end
            5'd8: reads_rs = 1'b1;
            5'd9: begin
                reads_rd  = 1'b1;
                reads_rt  = 1'b1;
                writes_rd = 1'b1;
            end
            5'd1, 5'd6: writes_rd = 1'b1;
            default: ;
        endcase
    end

    // Depends only on registered state and the instruction, never on writeback valids.
    assign issue_ready = !((reads_rs  && pending_q[rs_idx]) ||
                           (reads_rt  && pending_q[rt_idx]) ||
                           (reads_rd  && pending_q[rd_idx]) ||
                           (writes_rd && pending_q[rd_idx]) ||
                           (writes_rd && (pend_count_q == 6'(MAX_OUT))));
    assign issue_fire  = issue_valid && issue_ready;

    // Grants are suppressed during reset so a source keeps holding its write.
    assign grant_alu = !reset && alu_wb_valid && (!mem_wb_valid || rr_last_q == SRC_MEM);
    assign grant_mem = !reset && mem_wb_valid && (!alu_wb_valid || rr_last_q == SRC_ALU);
    assign grant_idx = grant_alu ? alu_wb_rd[RIW-1:0] : mem_wb_rd[RIW-1:0];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_fire && writes_rd)
            set_mask[rd_idx] = 1'b1;
        if (rf_wr_en_q)
            clr_mask[rf_wr_addr_q[RIW-1:0]] = 1'b1;

        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pend_count_d = '0;
        for (int i = 0; i < NREGS; i++)
            pend_count_d = pend_count_d + {5'd0, pending_d[i]};

        rf_wr_en_d   = grant_alu || grant_mem;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        if (grant_alu) begin
            rf_wr_addr_d = alu_wb_rd;
            rf_wr_data_d = alu_wb_data;
        end else if (grant_mem) begin
            rf_wr_addr_d = mem_wb_rd;
            rf_wr_data_d = mem_wb_data;
        end

        // A register whose clear is landing this cycle already counts as not pending.
        wb_err_d = wb_err_q ||
                   (rf_wr_en_d && !(pending_q[grant_idx] && !clr_mask[grant_idx]));

        rr_last_d = rr_last_q;
        if (alu_wb_valid && mem_wb_valid && !reset)
            rr_last_d = grant_alu ? SRC_ALU : SRC_MEM;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q    <= '0;
            pend_count_q <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            wb_err_q     <= 1'b0;
            rr_last_q    <= SRC_MEM;
        end else begin
            pending_q    <= pending_d;
            pend_count_q <= pend_count_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            wb_err_q     <= wb_err_d;
            rr_last_q    <= rr_last_d;
        end
    end

    assign alu_wb_ready = grant_alu;
    assign mem_wb_ready = grant_mem;
    assign rf_wr_en     = rf_wr_en_q;
    assign rf_wr_addr   = rf_wr_addr_q;
    assign rf_wr_data   = rf_wr_data_q;
    assign pend_count   = pend_count_q;
    assign wb_err       = wb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_scoreboard_arbiter
//  Purpose  : Scenario bench; expected register-file writes are queued when a
//             writeback is driven and compared when the write port fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_scoreboard_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_instr = '0;
    logic        issue_ready;
    logic        alu_wb_valid = 1'b0;
    logic [8:0]  alu_wb_rd = '0;
    logic [31:0] alu_wb_data = '0;
    logic        alu_wb_ready;
    logic        mem_wb_valid = 1'b0;
    logic [8:0]  mem_wb_rd = '0;
    logic [31:0] mem_wb_data = '0;
    logic        mem_wb_ready;
    logic        rf_wr_en;
    logic [8:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [5:0]  pend_count;
    logic        wb_err;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clock = ~clock;

    wb_scoreboard_arbiter #(.NREGS(32), .IDXW(9), .MAX_OUT(8)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
        .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
        .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd),
        .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .pend_count(pend_count), .wb_err(wb_err)
    );

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt);
        logic [31:0] v;
        v        = '0;
        v[31:27] = op[4:0];
        v[26:18] = rd[8:0];
        v[17:9]  = rs[8:0];
        v[8:0]   = rt[8:0];
        return v;
    endfunction

    // Write-port monitor: every rf_wr_en pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (rf_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h, none expected",
                         rf_wr_addr, rf_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_wr_addr !== e.addr || rf_wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write_port: got addr %0d data %h, want addr %0d data %h",
                             rf_wr_addr, rf_wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        issue_instr = mk(2, 1, 2, 3);
        #1;
        checks++;
        if (rf_wr_en !== 1'b0 || rf_wr_addr !== 9'd0 || rf_wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_wport: got en %b addr %0d data %h, want 0 0 0",
                     rf_wr_en, rf_wr_addr, rf_wr_data);
        end
        checks++;
        if (pend_count !== 6'd0 || wb_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got pend %0d err %b, want 0 0", pend_count, wb_err);
        end
        checks++;
        if (issue_ready !== 1'b1 || alu_wb_ready !== 1'b0 || mem_wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got issue %b alu %b mem %b, want 1 0 0",
                     issue_ready, alu_wb_ready, mem_wb_ready);
        end
    endtask

    task automatic test_raw();
        @(negedge clock);
        issue_valid = 1'b1;
        issue_instr = 32'h1004_0403;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_first_ready: got %b want 1", issue_ready);
        end
        @(negedge clock);
        issue_instr  = mk(2, 4, 1, 5);
        alu_wb_valid = 1'b1;
        alu_wb_rd    = 9'd1;
        alu_wb_data  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (pend_count !== 6'd1 || issue_ready !== 1'b0 || alu_wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall: got pend %0d ready %b alu_rdy %b, want 1 0 1",
                     pend_count, issue_ready, alu_wb_ready);
        end
        exp_q.push_back('{addr: 9'd1, data: 32'hDEAD_BEEF});
        @(negedge clock);
        alu_wb_valid = 1'b0;
        #1;
        checks++;
        if (rf_wr_en !== 1'b1 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_write_cycle: got en %b ready %b, want 1 0", rf_wr_en, issue_ready);
        end
        @(negedge clock);
        issue_valid = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || pend_count !== 6'd0) begin
            errors++;
            $display("FAIL raw_release: got ready %b pend %0d, want 1 0", issue_ready, pend_count);
        end
    endtask

    task automatic test_arbitration();
        for (int r = 5; r <= 7; r++) begin
            @(negedge clock);
            issue_valid = 1'b1;
            issue_instr = mk(1, r, 0, 0);
            #1;
            checks++;
            if (issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL arb_issue_r%0d: got %b want 1", r, issue_ready);
            end
        end
        @(negedge clock);
        issue_valid  = 1'b0;
        alu_wb_valid = 1'b1; alu_wb_rd = 9'd5; alu_wb_data = 32'hA5A5_0005;
        mem_wb_valid = 1'b1; mem_wb_rd = 9'd6; mem_wb_data = 32'hB6B6_0006;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b1 || mem_wb_ready !== 1'b0 || pend_count !== 6'd3) begin
            errors++;
            $display("FAIL arb_tie1: got alu %b mem %b pend %0d, want 1 0 3",
                     alu_wb_ready, mem_wb_ready, pend_count);
        end
        exp_q.push_back('{addr: 9'd5, data: 32'hA5A5_0005});
        @(negedge clock);
        alu_wb_rd = 9'd7; alu_wb_data = 32'hC7C7_0007;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b0 || mem_wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL arb_tie2: got alu %b mem %b, want 0 1", alu_wb_ready, mem_wb_ready);
        end
        exp_q.push_back('{addr: 9'd6, data: 32'hB6B6_0006});
        @(negedge clock);
        mem_wb_valid = 1'b0;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b1 || mem_wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL arb_single: got alu %b mem %b, want 1 0", alu_wb_ready, mem_wb_ready);
        end
        exp_q.push_back('{addr: 9'd7, data: 32'hC7C7_0007});
        @(negedge clock);
        alu_wb_valid = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (pend_count !== 6'd0) begin
            errors++;
            $display("FAIL arb_drained: got pend %0d want 0", pend_count);
        end
    endtask

    task automatic test_limit();
        for (int r = 1; r <= 8; r++) begin
            @(negedge clock);
            issue_valid = 1'b1;
            issue_instr = mk(1, r, 0, 0);
            #1;
            checks++;
            if (issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL limit_issue_r%0d: got %b want 1", r, issue_ready);
            end
        end
        @(negedge clock);
        issue_instr = mk(6, 9, 0, 0);
        #1;
        checks++;
        if (pend_count !== 6'd8 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL limit_full: got pend %0d ready %b, want 8 0", pend_count, issue_ready);
        end
        @(negedge clock);
        issue_instr = mk(7, 0, 0, 0);
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL limit_branch: got %b want 1", issue_ready);
        end
        @(negedge clock);
        issue_instr  = mk(6, 9, 0, 0);
        alu_wb_valid = 1'b1; alu_wb_rd = 9'd1; alu_wb_data = 32'h0000_1111;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b1 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL limit_grant: got alu %b ready %b, want 1 0", alu_wb_ready, issue_ready);
        end
        exp_q.push_back('{addr: 9'd1, data: 32'h0000_1111});
        @(negedge clock);
        alu_wb_valid = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b0 || pend_count !== 6'd8) begin
            errors++;
            $display("FAIL limit_wcycle: got ready %b pend %0d, want 0 8", issue_ready, pend_count);
        end
        @(negedge clock);
        #1;
        checks++;
        if (issue_ready !== 1'b1 || pend_count !== 6'd7) begin
            errors++;
            $display("FAIL limit_release: got ready %b pend %0d, want 1 7", issue_ready, pend_count);
        end
        @(negedge clock);
        issue_valid = 1'b0;
        #1;
        checks++;
        if (pend_count !== 6'd8) begin
            errors++;
            $display("FAIL limit_refill: got pend %0d want 8", pend_count);
        end
    endtask

    // r2..r9 pending on entry.
    task automatic test_hazard_decode();
        logic [31:0] instrs [10];
        logic        want   [10];
        instrs[0] = mk(1, 3, 0, 0);      want[0] = 1'b0;
        instrs[1] = mk(9, 3, 0, 0);      want[1] = 1'b0;
        instrs[2] = mk(9, 10, 0, 3);     want[2] = 1'b0;
        instrs[3] = mk(8, 0, 3, 0);      want[3] = 1'b0;
        instrs[4] = mk(8, 3, 0, 0);      want[4] = 1'b1;
        instrs[5] = mk(2, 10, 0, 'h23);  want[5] = 1'b0;
        instrs[6] = mk(0, 3, 3, 3);      want[6] = 1'b1;
        instrs[7] = mk(10, 3, 3, 3);     want[7] = 1'b1;
        instrs[8] = mk(7, 3, 3, 3);      want[8] = 1'b1;
        instrs[9] = mk(12, 3, 3, 3);     want[9] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            issue_valid = 1'b0;
            issue_instr = instrs[k];
            #1;
            checks++;
            if (issue_ready !== want[k]) begin
                errors++;
                $display("FAIL hazard_case%0d: instr %h got %b want %b",
                         k, instrs[k], issue_ready, want[k]);
            end
        end
        @(negedge clock);
        issue_valid  = 1'b1;
        issue_instr  = mk(1, 3, 0, 0);
        mem_wb_valid = 1'b1; mem_wb_rd = 9'd3; mem_wb_data = 32'h3333_0003;
        #1;
        checks++;
        if (mem_wb_ready !== 1'b1 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_grant: got mem %b ready %b, want 1 0", mem_wb_ready, issue_ready);
        end
        exp_q.push_back('{addr: 9'd3, data: 32'h3333_0003});
        @(negedge clock);
        mem_wb_valid = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_wcycle: got %b want 0", issue_ready);
        end
        @(negedge clock);
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_release: got %b want 1", issue_ready);
        end
        @(negedge clock);
        issue_valid = 1'b0;
        #1;
        checks++;
        if (pend_count !== 6'd8) begin
            errors++;
            $display("FAIL waw_reissue: got pend %0d want 8", pend_count);
        end
    endtask

    task automatic test_err_and_reset();
        @(negedge clock);
        mem_wb_valid = 1'b1; mem_wb_rd = 9'd12; mem_wb_data = 32'h1212_CAFE;
        #1;
        checks++;
        if (mem_wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_grant: got %b want 1", mem_wb_ready);
        end
        exp_q.push_back('{addr: 9'd12, data: 32'h1212_CAFE});
        @(negedge clock);
        mem_wb_valid = 1'b0;
        #1;
        checks++;
        if (rf_wr_en !== 1'b1 || wb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got en %b err %b, want 1 1", rf_wr_en, wb_err);
        end
        @(negedge clock);
        #1;
        checks++;
        if (wb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", wb_err);
        end
        @(negedge clock);
        reset = 1'b1;
        alu_wb_valid = 1'b1; alu_wb_rd = 9'd2; alu_wb_data = 32'h2222_0002;
        @(negedge clock);
        reset = 1'b0;
        alu_wb_valid = 1'b0;
        issue_instr  = mk(2, 1, 2, 3);
        #1;
        checks++;
        if (rf_wr_en !== 1'b0 || wb_err !== 1'b0 || pend_count !== 6'd0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got en %b err %b pend %0d ready %b, want 0 0 0 1",
                     rf_wr_en, wb_err, pend_count, issue_ready);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        alu_wb_valid = 1'b1; alu_wb_rd = 9'd20; alu_wb_data = 32'h2020_2020;
        mem_wb_valid = 1'b1; mem_wb_rd = 9'd21; mem_wb_data = 32'h2121_2121;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b1 || mem_wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got alu %b mem %b, want 1 0", alu_wb_ready, mem_wb_ready);
        end
        exp_q.push_back('{addr: 9'd20, data: 32'h2020_2020});
        @(negedge clock);
        alu_wb_valid = 1'b0;
        #1;
        checks++;
        if (mem_wb_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got mem %b want 1", mem_wb_ready);
        end
        exp_q.push_back('{addr: 9'd21, data: 32'h2121_2121});
        @(negedge clock);
        mem_wb_valid = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d outstanding writes want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_arbitration();
        test_limit();
        test_hazard_decode();
        test_err_and_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
